fpu_round: RTL

- Post-processing stage on the output side of the adder/subtractor: consumes sign, exponent, fraction and guard/round/sticky (GRS) bits from fadd_sub.
- Applies the IEEE-754 rounding mode and handles the carry into the exponent.
- Saturates on overflow and packs the final single-precision word with inexact/overflow flags.
- Uses the same level-enable / ready handshake as fadd_sub.

---
 rtl/fpu_pkg.sv | 44 ++++
 rtl/fpu_round_inc.sv | 38 +++
 rtl/fpu_round.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_pkg                                                    |
// | Brief   : Shared types and constants for the FPU rounding path:      |
// |           rounding-mode enum, rounder FSM states, exponent limits    |
// |           and the raw-mode decoder.                                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fpu_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rmode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } fround_state_e;

  localparam logic [7:0] EXP_MAX    = 8'hFF;
  localparam logic [7:0] EXP_MAXFIN = 8'hFE;

  // Unused encodings 101..111 fall back to round-to-nearest-even.
  function automatic rmode_e decode_rmode(input logic [2:0] raw);
    rmode_e m;
    case (raw)
      3'b000:  m = RNE;
      3'b001:  m = RTZ;
      3'b010:  m = RDN;
      3'b011:  m = RUP;
      3'b100:  m = RMM;
      default: m = RNE;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_round_inc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_round_inc                                              |
// | Brief   : Combinational round-increment decision from rounding mode, |
// |           sign, result LSB and guard/round/sticky bits. Shared by    |
// |           any FPU datapath that needs IEEE-754 rounding.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fpu_round_inc
  import fpu_pkg::*;
(
  input  logic [2:0] rmode_i,
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       round_i,
  input  logic       sticky_i,
  output logic       inc_o
);

  logic any_lost;
  assign any_lost = guard_i | round_i | sticky_i;

  // Decide whether the magnitude must be bumped by one ULP.
  always_comb begin
    inc_o = 1'b0;
    case (decode_rmode(rmode_i))
      RNE:     inc_o = guard_i & (round_i | sticky_i | lsb_i);
      RTZ:     inc_o = 1'b0;
      RDN:     inc_o = sign_i & any_lost;
      RUP:     inc_o = ~sign_i & any_lost;
      RMM:     inc_o = guard_i;
      default: inc_o = guard_i & (round_i | sticky_i | lsb_i);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fpu_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_round                                                  |
// | Brief   : Rounding / packing stage after fadd_sub. Applies the       |
// |           rounding mode, propagates fraction carry into the          |
// |           exponent, saturates on overflow and packs the single-      |
// |           precision word with inexact/overflow flags. Level-enable / |
// |           ready handshake, four-state FSM (IDLE/ROUND/NORM/DONE).    |
// | Option  : FPU_ROUND_STICKY_FLAGS_EN adds an accumulating flag        |
// |           register with fround_flag_clr_i / fround_flags_o.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fpu_round
  import fpu_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 32,
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23
) (
  input  logic                      fpu_clk,
  input  logic                      fpu_rst_n,
  input  logic                      fround_en_i,
  input  logic [2:0]                fround_rmode_i,
  input  logic                      fround_sign_i,
  input  logic [EXPONENT_WIDTH-1:0] fround_exp_i,
  input  logic [FRACTION_WIDTH-1:0] fround_frac_i,
  input  logic [2:0]                fround_grs_i,
  output logic [OPERAND_WIDTH-1:0]  fround_result_o,
  output logic                      fround_inexact_o,
  output logic                      fround_overflow_o,
  output logic                      fround_ready_o
`ifdef FPU_ROUND_STICKY_FLAGS_EN
  ,
  input  logic                      fround_flag_clr_i,
  output logic [1:0]                fround_flags_o
`endif
);

  localparam int SUM_WIDTH = EXPONENT_WIDTH + FRACTION_WIDTH;
  localparam logic [EXPONENT_WIDTH-1:0] EXP_ALL1   = EXPONENT_WIDTH'(EXP_MAX);
  localparam logic [EXPONENT_WIDTH-1:0] EXP_FINMAX = EXPONENT_WIDTH'(EXP_MAXFIN);

  fround_state_e state_q, state_d;

  logic [2:0]                rmode_q;
  logic                      sign_q;
  logic [EXPONENT_WIDTH-1:0] exp_q;
  logic [FRACTION_WIDTH-1:0] frac_q;
  logic [2:0]                grs_q;
  logic [SUM_WIDTH-1:0]      sum_q, sum_d;
  logic [OPERAND_WIDTH-1:0]  result_q, result_d;
  logic                      inexact_q, inexact_d;
  logic                      overflow_q, overflow_d;
  logic                      ready_q;

  logic                      special;
  logic                      inc_raw;
  logic                      inc_eff;
  logic [EXPONENT_WIDTH-1:0] sum_exp;
  logic [OPERAND_WIDTH-1:0]  inf_word;
  logic [OPERAND_WIDTH-1:0]  max_word;

  // Increment decision on the captured operand.
  fpu_round_inc u_inc (
    .rmode_i  (rmode_q),
    .sign_i   (sign_q),
    .lsb_i    (frac_q[0]),
    .guard_i  (grs_q[2]),
    .round_i  (grs_q[1]),
    .sticky_i (grs_q[0]),
    .inc_o    (inc_raw)
  );

  // Inf/NaN inputs bypass rounding entirely.
  assign special = (exp_q == EXP_ALL1);
  assign inc_eff = inc_raw & ~special;

  // Exponent and fraction are summed as one word so that an all-ones
  // fraction carries straight into the exponent (incl. denormal -> exp 1).
  assign sum_d   = {exp_q, frac_q} + SUM_WIDTH'(inc_eff);
  assign sum_exp = sum_q[SUM_WIDTH-1 -: EXPONENT_WIDTH];

  assign inf_word = {sign_q, EXP_ALL1, {FRACTION_WIDTH{1'b0}}};
  assign max_word = {sign_q, EXP_FINMAX, {FRACTION_WIDTH{1'b1}}};

  // Overflow detection and final word selection from the rounded sum.
  always_comb begin
    result_d   = {sign_q, sum_q};
    overflow_d = 1'b0;
    inexact_d  = |grs_q;
    if (special) begin
      result_d   = {sign_q, exp_q, frac_q};
      overflow_d = 1'b0;
      inexact_d  = 1'b0;
    end else if (sum_exp == EXP_ALL1) begin
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
      case (decode_rmode(rmode_q))
        RNE:     result_d = inf_word;
        RMM:     result_d = inf_word;
        RTZ:     result_d = max_word;
        RDN:     result_d = sign_q ? inf_word : max_word;
        RUP:     result_d = sign_q ? max_word : inf_word;
        default: result_d = inf_word;
      endcase
    end
  end

  // Next-state logic for the handshake sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fround_en_i) state_d = ROUND;
      ROUND:   state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (!fround_en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Operand capture (IDLE only), rounded sum (ROUND), registered outputs (NORM).
  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) begin
      rmode_q    <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      frac_q     <= '0;
      grs_q      <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && fround_en_i) begin
        rmode_q <= fround_rmode_i;
        sign_q  <= fround_sign_i;
        exp_q   <= fround_exp_i;
        frac_q  <= fround_frac_i;
        grs_q   <= fround_grs_i;
      end
      if (state_q == ROUND) sum_q <= sum_d;
      if (state_q == NORM) begin
        result_q   <= result_d;
        inexact_q  <= inexact_d;
        overflow_q <= overflow_d;
      end
      ready_q <= (state_d == DONE);
    end
  end

  assign fround_result_o   = result_q;
  assign fround_inexact_o  = inexact_q;
  assign fround_overflow_o = overflow_q;
  assign fround_ready_o    = ready_q;

`ifdef FPU_ROUND_STICKY_FLAGS_EN
  logic [1:0] flags_q, flags_d;

  // Clear first, then OR in the new result so a same-cycle set survives.
  always_comb begin
    flags_d = fround_flag_clr_i ? 2'b00 : flags_q;
    if (state_q == NORM) flags_d = flags_d | {overflow_d, inexact_d};
  end

  // Sticky flag register.
  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) flags_q <= 2'b00;
    else            flags_q <= flags_d;
  end

  assign fround_flags_o = flags_q;
`endif

endmodule
`default_nettype wire
